serial_paralelo_rx: RTL and testbench
=====================================

Name: serial_paralelo_rx

Overview:
- Receive-side front end of the phy link; consumes the single-bit serial stream produced by the phy_tx parallel-to-serial stage.
- Runs on the bit clock and finds byte alignment by locking onto repeated COM (8'hBC) idle symbols.
- Once aligned, it deserializes bytes and presents them with a valid flag to the rx byte-striping and demux stages.

Parameters:
- COM_SYMBOL, 8'hBC, idle/alignment symbol transmitted by phy_tx while its valid inputs are low.
- BC_NEEDED, 4, number of consecutive byte-aligned COM symbols required to declare the link active (legal range 1..7).

Ports:
- clk_32f  input  1  bit clock; one serial bit sampled per rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial bit from phy_tx; MSB of each byte first.
- active_out  output  1  high once alignment is achieved (state ACTIVE).
- data_out  output  8  last deserialized non-COM byte; held between byte boundaries.
- valid_out  output  1  high while data_out holds a payload byte received in ACTIVE; low for COM bytes.
- byte_strobe  output  1  one-cycle pulse on every byte boundary in ACTIVE.

Behaviour:
- Shift path:
  - shift_next = {shift[6:0], data_in}.
  - shift <= shift_next every cycle in every non-reset state.
- Reset (reset==0, async):
  - State goes to SEARCH; shift=0, bit_cnt=0, bc_cnt=0.
  - Outputs: active_out=0, data_out=8'h00, valid_out=0, byte_strobe=0.
  - Reset asserted mid-byte or mid-ACTIVE discards the partial byte immediately.
- SEARCH:
  - Compares shift_next to COM_SYMBOL every cycle (bit-granular search).
  - On match: bit_cnt<=0, bc_cnt<=1. If BC_NEEDED==1, go to ACTIVE; else go to LOCKING.
  - Otherwise stay in SEARCH.
- LOCKING:
  - bit_cnt increments modulo 8.
  - When bit_cnt==7 (byte boundary) and shift_next==COM_SYMBOL: bc_cnt++. If the new bc_cnt==BC_NEEDED, go to ACTIVE.
  - When bit_cnt==7 and shift_next!=COM_SYMBOL: bc_cnt<=0, go to SEARCH. Bit-level search restarts on the next cycle; no re-check of this window.
  - Outputs stay at their reset values in this state.
- ACTIVE:
  - active_out=1 (registered, asserted the cycle after the locking COM completes).
  - bit_cnt wraps 7->0 continuously.
  - At bit_cnt==7, next edge: byte_strobe<=1.
    - If shift_next!=COM_SYMBOL: data_out<=shift_next, valid_out<=1.
    - Else: valid_out<=0 and data_out retains its previous value.
  - byte_strobe deasserts the following cycle.
  - data_out and valid_out hold for the full 8 cycles until the next boundary.
  - ACTIVE is left only via reset; COM bytes in ACTIVE are idle, not loss of lock.
- Latency: last bit of a byte sampled at edge N; data_out/valid_out/byte_strobe update at that same edge N (registered from shift_next). Visible to consumers from edge N until edge N+8.
- Counters: bit_cnt is 3 bits; bc_cnt is 3 bits, saturation not needed given the BC_NEEDED range.
- Misaligned COM lookalikes (e.g. 8'hBC spanning two payload bytes) in SEARCH cause a false start. The false lock is rejected by the boundary check in LOCKING.

Test Plan:
- Reset mid-stream: drive random bits, pull reset low for 3 cycles -> all outputs 0 immediately, state SEARCH; release then 4×8'hBC aligned -> active_out=1 one cycle after 32nd COM bit.
- Lock with offset: 3 junk bits then 4×BC then bytes CC,FD,AA,12 -> active_out high, then byte_strobe every 8 cycles, data_out=CC,FD,AA,12 each with valid_out=1.
- Interrupted locking: BC,BC,0x55,BC,BC,BC,BC -> active_out stays 0 through 0x55, bc_cnt resets, asserts only after final 4 consecutive BC.
- Idle in ACTIVE: after lock send CC,BC,BC,FD -> valid_out 1,0,0,1; data_out stays CC through the BC bytes; byte_strobe pulses on all 4 boundaries; active_out stays 1.
- Bit-order check: after lock send 8'h80 then 8'h01 -> data_out=80 then 01 (MSB-first), valid_out=1 both.
- BC_NEEDED=1 build: single aligned BC -> active_out=1 next cycle; following 8'hA5 -> data_out=A5, valid_out=1.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receive front end: finds byte alignment by locking onto
// repeated COM idle symbols, then deserializes MSB-first bytes with a valid flag.
module serial_paralelo_rx #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         BC_NEEDED  = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       active_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe
);

  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  localparam logic [2:0] BC_TARGET = 3'(BC_NEEDED);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_next;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bc_cnt_q, bc_cnt_d;
  logic [2:0] bc_inc;
  logic       com_match;
  logic       boundary;

  assign shift_next = {shift_q[6:0], data_in};
  assign com_match  = (shift_next == COM_SYMBOL);
  assign boundary   = (bit_cnt_q == 3'd7);
  assign bc_inc     = bc_cnt_q + 3'd1;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_next;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    case (state_q)
      SEARCH: begin
        // Bit-granular hunt: any window matching COM becomes the candidate alignment
        if (com_match) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 3'd1;
          state_d   = (BC_NEEDED == 1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (com_match) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_TARGET) state_d = ACTIVE;
          end else begin
            bc_cnt_d = 3'd0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // COM bytes in ACTIVE are idle: strobe still pulses, data_out keeps the last payload
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      active_out  <= 1'b0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      active_out  <= (state_d == ACTIVE);
      byte_strobe <= (state_q == ACTIVE) && boundary;
      if ((state_q == ACTIVE) && boundary) begin
        valid_out <= !com_match;
        if (!com_match) data_out <= shift_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed lock/idle/bit-order sequences plus
// random streams compared every bit against a bit-history reference model.
module tb_serial_paralelo_rx;

  localparam logic [7:0] BC = 8'hBC;
  localparam int         N  = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic       active_out, valid_out, byte_strobe;
  logic [7:0] data_out;
  logic       active1, valid1, strobe1;
  logic [7:0] data1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_paralelo_rx #(.COM_SYMBOL(BC), .BC_NEEDED(N)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .active_out(active_out), .data_out(data_out),
    .valid_out(valid_out), .byte_strobe(byte_strobe)
  );

  serial_paralelo_rx #(.COM_SYMBOL(BC), .BC_NEEDED(1)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .active_out(active1), .data_out(data1),
    .valid_out(valid1), .byte_strobe(strobe1)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: keeps every received bit since reset and judges each
  // 8-bit window by its distance (in bits) from the last alignment anchor.
  logic       hist[$];
  int         m_mode;   // 0 hunting, 1 counting COMs, 2 aligned
  int         m_anchor;
  int         m_count;
  logic       m_active, m_valid, m_strobe;
  logic [7:0] m_data;

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_anchor = 0; m_count = 0;
    m_active = 1'b0; m_valid = 1'b0; m_strobe = 1'b0; m_data = 8'h00;
  endtask

  task automatic model_step(input logic b);
    int t;
    logic [7:0] w;
    hist.push_back(b);
    t = hist.size() - 1;
    w = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      int idx;
      idx = t - i;
      w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      if (w == BC) begin
        m_anchor = t;
        m_count  = 1;
        m_mode   = (m_count == N) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if ((t - m_anchor) % 8 == 0) begin
        if (w == BC) begin
          m_count++;
          if (m_count == N) m_mode = 2;
        end else begin
          m_count = 0;
          m_mode  = 0;
        end
      end
    end else begin
      if ((t - m_anchor) % 8 == 0) begin
        m_strobe = 1'b1;
        m_valid  = (w != BC);
        if (w != BC) m_data = w;
      end
    end
    m_active = (m_mode == 2);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    model_step(b);
    @(posedge clk_32f);
    #1;
    check("model", {21'd0, active_out, data_out, valid_out, byte_strobe},
          {21'd0, m_active, m_data, m_valid, m_strobe});
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    check("rst_outputs", {active_out, data_out, valid_out, byte_strobe}, 11'd0);
    check("rst_outputs1", {active1, data1, valid1, strobe1}, 11'd0);
    model_reset();
    repeat (cycles) @(posedge clk_32f);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [7:0] byte_in;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] prev_data;
    logic [7:0] com;
    logic [7:0] a5;
    logic       prev_valid;

    vecs[0] = '{8'hCC, 8'hCC, 1'b1};
    vecs[1] = '{8'hFD, 8'hFD, 1'b1};
    vecs[2] = '{8'hAA, 8'hAA, 1'b1};
    vecs[3] = '{8'h12, 8'h12, 1'b1};
    vecs[4] = '{8'hCC, 8'hCC, 1'b1};
    vecs[5] = '{8'hBC, 8'hCC, 1'b0};
    vecs[6] = '{8'hBC, 8'hCC, 1'b0};
    vecs[7] = '{8'hFD, 8'hFD, 1'b1};
    vecs[8] = '{8'h80, 8'h80, 1'b1};
    vecs[9] = '{8'h01, 8'h01, 1'b1};

    // Reset mid-stream, then an aligned lock
    do_reset(2);
    for (int i = 0; i < 13; i++) send_bit(1'($urandom % 2));
    do_reset(3);
    send_byte(BC); send_byte(BC); send_byte(BC);
    com = BC;
    for (int i = 7; i >= 1; i--) send_bit(com[i]);
    check("lock_before_32", {31'd0, active_out}, 32'd0);
    send_bit(com[0]);
    check("lock_at_32", {31'd0, active_out}, 32'd1);

    // Lock with bit offset, then payload / idle / bit-order table
    do_reset(2);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int k = 0; k < 4; k++) send_byte(BC);
    check("offset_lock", {31'd0, active_out}, 32'd1);
    prev_data  = 8'h00;
    prev_valid = 1'b0;
    for (int v = 0; v < 10; v++) begin
      logic [7:0] b;
      b = vecs[v].byte_in;
      for (int i = 7; i >= 4; i--) send_bit(b[i]);
      check("hold_data", {24'd0, data_out}, {24'd0, prev_data});
      check("hold_valid", {31'd0, valid_out}, {31'd0, prev_valid});
      check("mid_strobe", {31'd0, byte_strobe}, 32'd0);
      for (int i = 3; i >= 0; i--) send_bit(b[i]);
      check("vec_strobe", {31'd0, byte_strobe}, 32'd1);
      check("vec_data", {24'd0, data_out}, {24'd0, vecs[v].exp_data});
      check("vec_valid", {31'd0, valid_out}, {31'd0, vecs[v].exp_valid});
      check("vec_active", {31'd0, active_out}, 32'd1);
      prev_data  = vecs[v].exp_data;
      prev_valid = vecs[v].exp_valid;
    end

    // Interrupted locking
    do_reset(2);
    send_byte(BC); send_byte(BC);
    check("intr_bc2", {31'd0, active_out}, 32'd0);
    send_byte(8'h55);
    check("intr_55", {31'd0, active_out}, 32'd0);
    send_byte(BC); send_byte(BC); send_byte(BC);
    check("intr_bc3", {31'd0, active_out}, 32'd0);
    send_byte(BC);
    check("intr_bc4", {31'd0, active_out}, 32'd1);

    // Single-COM lock build
    do_reset(2);
    for (int i = 7; i >= 1; i--) send_bit(com[i]);
    check("n1_before", {31'd0, active1}, 32'd0);
    send_bit(com[0]);
    check("n1_active", {31'd0, active1}, 32'd1);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(a5[i]);
    check("n1_data", {24'd0, data1}, 32'h0000_00A5);
    check("n1_valid", {31'd0, valid1}, 32'd1);
    check("n1_strobe", {31'd0, strobe1}, 32'd1);

    // Random streams against the model
    for (int r = 0; r < 6; r++) begin
      int junk;
      do_reset(1 + int'($urandom % 3));
      junk = int'($urandom % 8);
      for (int i = 0; i < junk; i++) send_bit(1'($urandom % 2));
      for (int k = 0; k < 60; k++) begin
        logic [7:0] b;
        b = ($urandom % 5 < 2) ? BC : 8'($urandom);
        send_byte(b);
      end
      for (int i = 0; i < junk; i++) send_bit(1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
